// File: rtl/button_conditioner.sv
// Button conditioner: per-button 2-flop synchroniser, counter debouncer and edge detector.
// Define BUTTON_AUTO_REPEAT_EN to add hold-to-repeat press pulses.

module button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES      = 270000,
    parameter int unsigned CNT_W                = 20,
    parameter int unsigned REPEAT_DELAY_CYCLES  = 13500000,
    parameter int unsigned REPEAT_PERIOD_CYCLES = 2700000,
    parameter int unsigned REP_W                = 24
) (
    input  logic crystalCLK,
    input  logic rst_n,
    input  logic btn_X_raw,
    input  logic btn_Y_raw,
    output logic btn_X_level,
    output logic btn_Y_level,
    output logic btn_X_press,
    output logic btn_Y_press,
    output logic btn_X_release,
    output logic btn_Y_release
);

    localparam int unsigned NCH = 2;
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 32'd1);

    // Elaboration-time parameter sanity checks
    if (DEBOUNCE_CYCLES < 32'd2 || 64'(DEBOUNCE_CYCLES) >= (64'd1 << CNT_W)) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must lie in 2 .. 2**CNT_W-1");
    end
    if (REPEAT_DELAY_CYCLES < 32'd1 || REPEAT_PERIOD_CYCLES < 32'd1
        || 64'(REPEAT_DELAY_CYCLES) > (64'd1 << REP_W)
        || 64'(REPEAT_PERIOD_CYCLES) > (64'd1 << REP_W)) begin : g_bad_repeat
        $error("REPEAT_*_CYCLES must lie in 1 .. 2**REP_W");
    end

    logic [NCH-1:0] raw_vec;
    logic [NCH-1:0] level_vec;
    logic [NCH-1:0] press_vec;
    logic [NCH-1:0] rel_vec;

    assign raw_vec = {btn_Y_raw, btn_X_raw};

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic             sync1_q;
        logic             sync2_q;
        logic             pressed_s;
        logic             stable_q;
        logic             stable_d;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             press_q;
        logic             press_d;
        logic             rel_q;
        logic             rel_d;
`ifdef BUTTON_AUTO_REPEAT_EN
        localparam logic [REP_W-1:0] REP_FIRST = REP_W'(REPEAT_DELAY_CYCLES - 32'd1);
        localparam logic [REP_W-1:0] REP_NEXT  = REP_W'(REPEAT_PERIOD_CYCLES - 32'd1);
        logic [REP_W-1:0] rep_q;
        logic [REP_W-1:0] rep_d;
`endif

        assign pressed_s = ~sync2_q;

        // Debounce, edge detect and (optionally) auto-repeat next-state
        always_comb begin
            cnt_d    = cnt_q;
            stable_d = stable_q;
            press_d  = 1'b0;
            rel_d    = 1'b0;
`ifdef BUTTON_AUTO_REPEAT_EN
            rep_d    = rep_q;
`endif
            if (pressed_s == stable_q) begin
                cnt_d = '0;
            end else if (cnt_q == DB_LAST) begin
                stable_d = pressed_s;
                cnt_d    = '0;
                press_d  = pressed_s;
                rel_d    = ~pressed_s;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
`ifdef BUTTON_AUTO_REPEAT_EN
            // Down-counter reloads at each pulse; a release on the same edge suppresses the repeat
            if (press_d) begin
                rep_d = REP_FIRST;
            end else if (!stable_q || rel_d) begin
                rep_d = '0;
            end else if (rep_q == '0) begin
                press_d = 1'b1;
                rep_d   = REP_NEXT;
            end else begin
                rep_d = rep_q - REP_W'(1);
            end
`endif
        end

        always_ff @(posedge crystalCLK or negedge rst_n) begin
            if (!rst_n) begin
                sync1_q  <= 1'b1;
                sync2_q  <= 1'b1;
                stable_q <= 1'b0;
                cnt_q    <= '0;
                press_q  <= 1'b0;
                rel_q    <= 1'b0;
`ifdef BUTTON_AUTO_REPEAT_EN
                rep_q    <= '0;
`endif
            end else begin
                sync1_q  <= raw_vec[i];
                sync2_q  <= sync1_q;
                stable_q <= stable_d;
                cnt_q    <= cnt_d;
                press_q  <= press_d;
                rel_q    <= rel_d;
`ifdef BUTTON_AUTO_REPEAT_EN
                rep_q    <= rep_d;
`endif
            end
        end

        assign level_vec[i] = stable_q;
        assign press_vec[i] = press_q;
        assign rel_vec[i]   = rel_q;
    end

    assign btn_X_level   = level_vec[0];
    assign btn_Y_level   = level_vec[1];
    assign btn_X_press   = press_vec[0];
    assign btn_Y_press   = press_vec[1];
    assign btn_X_release = rel_vec[0];
    assign btn_Y_release = rel_vec[1];

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: expected pulse events are queued at stimulus time
// and compared against pulses observed on the DUT outputs.

module tb_button_conditioner;

    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RP = 8;
    localparam int LAT = DB + 2;

    typedef struct {
        int cyc;
        int id;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n;
    logic x_raw;
    logic y_raw;
    logic x_level, y_level, x_press, y_press, x_rel, y_rel;

    ev_t exp_q[$];
    ev_t obs_q[$];
    int  cyc   = 0;
    int  n_cmp = 0;
    int  n_bad = 0;

    button_conditioner #(
        .DEBOUNCE_CYCLES      (DB),
        .CNT_W                (20),
        .REPEAT_DELAY_CYCLES  (RD),
        .REPEAT_PERIOD_CYCLES (RP),
        .REP_W                (24)
    ) dut (
        .crystalCLK    (clk),
        .rst_n         (rst_n),
        .btn_X_raw     (x_raw),
        .btn_Y_raw     (y_raw),
        .btn_X_level   (x_level),
        .btn_Y_level   (y_level),
        .btn_X_press   (x_press),
        .btn_Y_press   (y_press),
        .btn_X_release (x_rel),
        .btn_Y_release (y_rel)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic ev_t mk_ev(input int c, input int id);
        ev_t e;
        e.cyc = c;
        e.id  = id;
        return e;
    endfunction

    // Pulse monitor: ids 0 X press, 1 X release, 2 Y press, 3 Y release
    always @(negedge clk) begin
        if (x_press) obs_q.push_back(mk_ev(cyc, 0));
        if (x_rel)   obs_q.push_back(mk_ev(cyc, 1));
        if (y_press) obs_q.push_back(mk_ev(cyc, 2));
        if (y_rel)   obs_q.push_back(mk_ev(cyc, 3));
    end

    task automatic test_reset();
        logic [5:0] outs;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            outs = {x_level, y_level, x_press, y_press, x_rel, y_rel};
            n_cmp++;
            if (outs !== 6'b0) begin
                n_bad++;
                $display("FAIL reset_held: outputs %b, required %b", outs, 6'b0);
            end
        end
        rst_n = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            outs = {x_level, y_level, x_press, y_press, x_rel, y_rel};
            n_cmp++;
            if (outs !== 6'b0) begin
                n_bad++;
                $display("FAIL reset_idle cycle %0d: outputs %b, required %b", cyc, outs, 6'b0);
            end
        end
        #1;
        n_cmp++;
        if (obs_q.size() !== 0) begin
            n_bad++;
            $display("FAIL reset_events: got %0d pulses, required 0", obs_q.size());
        end
        obs_q.delete();
    endtask

    task automatic test_press_release();
        int  t0, t1;
        ev_t e, o;
        exp_q.delete();
        obs_q.delete();
        @(negedge clk);
        t0 = cyc;
        x_raw = 1'b0;
        exp_q.push_back(mk_ev(t0 + LAT, 0));
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            n_cmp++;
            if (x_level !== (cyc >= t0 + LAT)) begin
                n_bad++;
                $display("FAIL press_level cycle %0d: got %b, required %b", cyc, x_level, (cyc >= t0 + LAT));
            end
        end
        t1 = cyc;
        x_raw = 1'b1;
        exp_q.push_back(mk_ev(t1 + LAT, 1));
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n_cmp++;
            if (x_level !== (cyc < t1 + LAT)) begin
                n_bad++;
                $display("FAIL release_level cycle %0d: got %b, required %b", cyc, x_level, (cyc < t1 + LAT));
            end
        end
        #1;
        while (exp_q.size() > 0 || obs_q.size() > 0) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                o = obs_q.pop_front();
                n_bad++;
                $display("FAIL press_release extra: got id %0d at %0d, required none", o.id, o.cyc);
            end else if (obs_q.size() == 0) begin
                e = exp_q.pop_front();
                n_bad++;
                $display("FAIL press_release missing: got none, required id %0d at %0d", e.id, e.cyc);
            end else begin
                e = exp_q.pop_front();
                o = obs_q.pop_front();
                if (o.cyc !== e.cyc || o.id !== e.id) begin
                    n_bad++;
                    $display("FAIL press_release event: got id %0d at %0d, required id %0d at %0d", o.id, o.cyc, e.id, e.cyc);
                end
            end
        end
    endtask

    task automatic test_glitch();
        int pat_len[4];
        logic pat_val[4];
        obs_q.delete();
        pat_len = '{3, 2, 3, 10};
        pat_val = '{1'b0, 1'b1, 1'b0, 1'b1};
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            x_raw = pat_val[s];
            for (int k = 0; k < pat_len[s]; k++) begin
                n_cmp++;
                if (x_level !== 1'b0) begin
                    n_bad++;
                    $display("FAIL glitch_level cycle %0d: got %b, required 0", cyc, x_level);
                end
                if (k != pat_len[s] - 1) @(negedge clk);
            end
        end
        #1;
        n_cmp++;
        if (obs_q.size() !== 0) begin
            n_bad++;
            $display("FAIL glitch_events: got %0d pulses, required 0", obs_q.size());
        end
    endtask

    task automatic test_simultaneous();
        int  t0, t1;
        ev_t e, o;
        exp_q.delete();
        obs_q.delete();
        @(negedge clk);
        t0 = cyc;
        x_raw = 1'b0;
        y_raw = 1'b0;
        exp_q.push_back(mk_ev(t0 + LAT, 0));
        exp_q.push_back(mk_ev(t0 + LAT, 2));
        repeat (10) @(negedge clk);
        n_cmp++;
        if ({x_level, y_level} !== 2'b11) begin
            n_bad++;
            $display("FAIL simul_levels: got %b, required 11", {x_level, y_level});
        end
        t1 = cyc;
        x_raw = 1'b1;
        y_raw = 1'b1;
        exp_q.push_back(mk_ev(t1 + LAT, 1));
        exp_q.push_back(mk_ev(t1 + LAT, 3));
        repeat (10) @(negedge clk);
        #1;
        while (exp_q.size() > 0 || obs_q.size() > 0) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                o = obs_q.pop_front();
                n_bad++;
                $display("FAIL simul extra: got id %0d at %0d, required none", o.id, o.cyc);
            end else if (obs_q.size() == 0) begin
                e = exp_q.pop_front();
                n_bad++;
                $display("FAIL simul missing: got none, required id %0d at %0d", e.id, e.cyc);
            end else begin
                e = exp_q.pop_front();
                o = obs_q.pop_front();
                if (o.cyc !== e.cyc || o.id !== e.id) begin
                    n_bad++;
                    $display("FAIL simul event: got id %0d at %0d, required id %0d at %0d", o.id, o.cyc, e.id, e.cyc);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int         t;
        ev_t        e, o;
        logic [5:0] outs;
        exp_q.delete();
        obs_q.delete();
        @(negedge clk);
        y_raw = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        outs = {x_level, y_level, x_press, y_press, x_rel, y_rel};
        n_cmp++;
        if (outs !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_midcount: outputs %b, required %b", outs, 6'b0);
        end
        repeat (2) @(negedge clk);
        t = cyc;
        rst_n = 1'b1;
        exp_q.push_back(mk_ev(t + LAT, 2));
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            n_cmp++;
            if (y_level !== (cyc >= t + LAT)) begin
                n_bad++;
                $display("FAIL reset_rearm_level cycle %0d: got %b, required %b", cyc, y_level, (cyc >= t + LAT));
            end
        end
        rst_n = 1'b0;
        #1;
        outs = {x_level, y_level, x_press, y_press, x_rel, y_rel};
        n_cmp++;
        if (outs !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_pressed: outputs %b, required %b", outs, 6'b0);
        end
        repeat (2) @(negedge clk);
        t = cyc;
        rst_n = 1'b1;
        exp_q.push_back(mk_ev(t + LAT, 2));
        repeat (8) @(negedge clk);
        t = cyc;
        y_raw = 1'b1;
        exp_q.push_back(mk_ev(t + LAT, 3));
        repeat (10) @(negedge clk);
        #1;
        while (exp_q.size() > 0 || obs_q.size() > 0) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                o = obs_q.pop_front();
                n_bad++;
                $display("FAIL reset_mid extra: got id %0d at %0d, required none", o.id, o.cyc);
            end else if (obs_q.size() == 0) begin
                e = exp_q.pop_front();
                n_bad++;
                $display("FAIL reset_mid missing: got none, required id %0d at %0d", e.id, e.cyc);
            end else begin
                e = exp_q.pop_front();
                o = obs_q.pop_front();
                if (o.cyc !== e.cyc || o.id !== e.id) begin
                    n_bad++;
                    $display("FAIL reset_mid event: got id %0d at %0d, required id %0d at %0d", o.id, o.cyc, e.id, e.cyc);
                end
            end
        end
    endtask

    task automatic test_auto_repeat();
        int  t0, t1;
        ev_t e, o;
        exp_q.delete();
        obs_q.delete();
        @(negedge clk);
        t0 = cyc;
        x_raw = 1'b0;
        exp_q.push_back(mk_ev(t0 + LAT, 0));
`ifdef BUTTON_AUTO_REPEAT_EN
        // The repeat that would land on the release edge is suppressed
        for (int r = t0 + LAT + RD; r < t0 + 60 + LAT; r += RP) exp_q.push_back(mk_ev(r, 0));
`endif
        repeat (60) @(negedge clk);
        t1 = cyc;
        x_raw = 1'b1;
        exp_q.push_back(mk_ev(t1 + LAT, 1));
        repeat (12) @(negedge clk);
        #1;
        while (exp_q.size() > 0 || obs_q.size() > 0) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                o = obs_q.pop_front();
                n_bad++;
                $display("FAIL auto_repeat extra: got id %0d at %0d, required none", o.id, o.cyc);
            end else if (obs_q.size() == 0) begin
                e = exp_q.pop_front();
                n_bad++;
                $display("FAIL auto_repeat missing: got none, required id %0d at %0d", e.id, e.cyc);
            end else begin
                e = exp_q.pop_front();
                o = obs_q.pop_front();
                if (o.cyc !== e.cyc || o.id !== e.id) begin
                    n_bad++;
                    $display("FAIL auto_repeat event: got id %0d at %0d, required id %0d at %0d", o.id, o.cyc, e.id, e.cyc);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        x_raw = 1'b1;
        y_raw = 1'b1;
        test_reset();
        test_press_release();
        test_glitch();
        test_simultaneous();
        test_reset_mid();
        test_auto_repeat();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Input conditioning stage upstream of the sprite animation logic; consumes the raw board buttons btn_X_raw and btn_Y_raw, which are active-low with idle = 1.
- Per button, in order: 2-flop synchroniser, counter-based debouncer, edge detector.
- Outputs are a clean active-high pressed level plus one-cycle press and release pulses; the sprite/animation FSMs act on these only.
- X and Y are two identical, fully independent channels.

Parameters:
- DEBOUNCE_CYCLES, 270000: consecutive cycles a new synchronised value must hold before it is accepted (10 ms at 27 MHz). Legal range 2 to 2^CNT_W-1.
- CNT_W, 20: debounce counter width.
- REPEAT_DELAY_CYCLES, 13500000: hold time before the first auto-repeat pulse. Used only with the optional feature.
- REPEAT_PERIOD_CYCLES, 2700000: interval between later auto-repeat pulses. Used only with the optional feature.
- REP_W, 24: auto-repeat counter width.

Ports:
- crystalCLK  input  1  27 MHz system clock; all logic is on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- btn_X_raw  input  1  raw button X, active-low, asynchronous to crystalCLK.
- btn_Y_raw  input  1  raw button Y, active-low, asynchronous to crystalCLK.
- btn_X_level  output  1  debounced X; 1 = pressed.
- btn_Y_level  output  1  debounced Y; 1 = pressed.
- btn_X_press  output  1  one-cycle pulse on accepted X press (and on auto-repeat).
- btn_Y_press  output  1  one-cycle pulse on accepted Y press (and on auto-repeat).
- btn_X_release  output  1  one-cycle pulse on accepted X release.
- btn_Y_release  output  1  one-cycle pulse on accepted Y release.

Behaviour:
- Reset (asynchronous assert, synchronous release by the user):
  - sync flops = 1 (released);
  - debounce counter = 0, repeat counter = 0;
  - all level and pulse outputs = 0.
- Synchroniser, per channel: sync1 <= raw; sync2 <= sync1; pressed_s = ~sync2.
- Debouncer, per channel, with stable = level register:
  - If pressed_s == stable: counter <= 0.
  - Else if counter == DEBOUNCE_CYCLES-1: stable <= pressed_s and counter <= 0.
  - Else: counter <= counter+1.
- Latency:
  - Let edge 1 be the first rising edge at which the new raw value is sampled.
  - level and the corresponding pulse update on edge DEBOUNCE_CYCLES+2.
  - All outputs are registered; there is no combinational path from input to output.
- Pulses:
  - press = 1 for exactly one cycle on the edge where stable goes 0->1.
  - release = 1 for exactly one cycle on the edge where stable goes 1->0.
  - press and release of the same channel are never high together.
- Glitch rejection:
  - Any disagreement run shorter than DEBOUNCE_CYCLES cycles clears the counter.
  - level is unchanged and no pulse is produced.
  - A bounce mid-count restarts the count from 0.
- Simultaneous events: X and Y may pulse on the same cycle; there is no arbitration or cross-coupling.
- Reset mid-operation:
  - All state clears immediately, including any partial count or pending repeat.
  - A button held through reset is treated as a new press after reset release: press pulse on edge DEBOUNCE_CYCLES+2.
- Counter wrap: unreachable, since the count is bounded by DEBOUNCE_CYCLES-1 < 2^CNT_W.

Optional Feature:
- Macro: BUTTON_AUTO_REPEAT_EN.
- Defined: while level stays 1, a per-channel repeat counter runs from the accepted press.
  - Extra press pulse at REPEAT_DELAY_CYCLES cycles after the original press pulse.
  - Then one every REPEAT_PERIOD_CYCLES cycles.
  - Counter clears when level drops, on release, or on reset.
  - A release pulse never coincides with a repeat pulse; release wins and the repeat is suppressed.
- Undefined: exactly one press pulse per accepted press. Repeat counters and REPEAT_* parameters are not synthesised.

Test Plan:
Bench parameters for all scenarios: DEBOUNCE_CYCLES=4, REPEAT_DELAY_CYCLES=20, REPEAT_PERIOD_CYCLES=8.
1. Reset, both raw held 1 for 50 cycles -> all outputs 0 throughout.
2. btn_X_raw 1->0 held 20 cycles, then 0->1 held -> btn_X_press high one cycle at edge 6 after first sampling edge; btn_X_level 1 from then until release; btn_X_release one cycle at edge 6 after release sampled; Y outputs stay 0.
3. btn_X_raw low 3 cycles, high 2, low 3, then high -> no pulses, btn_X_level stays 0.
4. btn_X_raw and btn_Y_raw fall on the same edge and are held -> btn_X_press and btn_Y_press high on the same cycle, both levels 1.
5. Hold btn_Y_raw low, assert rst_n=0 mid-count and after level=1, release reset -> outputs 0 immediately on assert; btn_Y_press at edge 6 after reset release.
6. With BUTTON_AUTO_REPEAT_EN, hold btn_X_raw low 60 cycles -> btn_X_press at press cycle P, P+20, P+28, P+36, ...; without the macro -> only at P.
